sata_link_pkt_fifo: RTL and testbench
=====================================

// Module: sata_link_pkt_fifo
// PURPOSE
//  Frame-aware synchronous FIFO for the SerialATA Link-layer RX/TX data paths.
//  Vendor-neutral, with parametrised width, depth and thresholds. Adds STORE_FORWARD
//  mode: a frame becomes readable only after its EOP is written, and a frame can be
//  discarded (wr_drop or overflow) before commit. Sits between the Link FSM and the
//  Transport layer.
// PARAMETERS
//  DWIDTH        32            data word width (eop carried alongside)
//  DEPTH         128           words; power of two, >= 4
//  ALMOST_EMPTY  2             rd_almostempty when readable words < ALMOST_EMPTY
//  ALMOST_FULL   DEPTH/2       wr_almostfull when stored words >= ALMOST_FULL
//  MODE          "CUT_THROUGH" "CUT_THROUGH" | "STORE_FORWARD"
// PORTS
//  clk            in   1          clock
//  reset          in   1          synchronous, active-high reset
//  wr_data        in   DWIDTH     write word
//  wr_eop         in   1          last word of frame
//  wr_req         in   1          write strobe
//  wr_drop        in   1          discard the uncommitted frame (STORE_FORWARD only)
//  wr_full        out  1          stored words == DEPTH
//  wr_almostfull  out  1          stored words >= ALMOST_FULL
//  wr_ovf         out  1          1-cycle pulse: wr_req rejected because full
//  rd_data        out  DWIDTH     head word (show-ahead)
//  rd_eop         out  1          head word is last of frame
//  rd_req         in   1          pop head word
//  rd_empty       out  1          no readable head word
//  rd_almostempty out  1          readable words < ALMOST_EMPTY
//  rd_frames      out  $clog2(DEPTH)+1  complete frames stored (incl. head)
// BEHAVIOUR
//  - Reset: all pointers and counters are 0. wr_full=0, wr_almostfull=0, wr_ovf=0,
//    rd_empty=1, rd_almostempty=1, rd_frames=0, rd_data=0, rd_eop=0, drop-pending=0.
//  - Pointers wr_ptr (speculative), cm_ptr (committed) and rd_ptr are $clog2(DEPTH)+1
//    bits wide and wrap modulo 2*DEPTH. stored = wr_ptr-rd_ptr.
//  - Write: accepted when wr_req & !wr_full. wr_full is taken from the current state;
//    a same-cycle rd_req does not free the slot.
//  - CUT_THROUGH: cm_ptr follows wr_ptr on every write. wr_drop and drop-pending are
//    ignored.
//  - STORE_FORWARD:
//    - An accepted word with wr_eop sets cm_ptr <= wr_ptr+1 and rd_frames+1.
//    - wr_drop sets wr_ptr <= cm_ptr. It wins over a same-cycle write, which is not
//      stored.
//    - A rejected write (overflow) sets drop-pending. While drop-pending is set,
//      further words are not stored.
//    - The EOP write that arrives while drop-pending is set rewinds wr_ptr <= cm_ptr,
//      clears drop-pending and does not change rd_frames.
//  - CUT_THROUGH rd_frames: +1 on each accepted eop word.
//  - rd_frames on read: -1 when the popped head has rd_eop=1. If it is incremented
//    and decremented in the same cycle, it holds.
//  - Read side: readable = cm_ptr-rd_ptr.
//    - A 1-deep output register is fed from the RAM with a 1-cycle read latency.
//      rd_empty=0 whenever the output register is valid.
//    - A word committed in cycle N is first shown on rd_data in cycle N+2 if the FIFO
//      was empty.
//    - rd_req & !rd_empty pops the head. With back-to-back rd_req the next word is
//      presented on the following cycle: 1 word per clock throughput.
//    - rd_req while rd_empty is ignored; pointers never underflow.
//  - wr_ovf is registered and asserts in the cycle after the rejected wr_req.
//  - rd_almostempty and wr_almostfull are combinational from the counts and pointers.
//  - reset mid-frame discards all contents, including any uncommitted frame. Outputs
//    take their reset values on the next clock edge.
// STRUCTURE
//  - Package sata_link_pkg holds the typedef sata_word_t (struct {logic eop;
//    logic [DWIDTH-1:0] data}) and the mode string constants.
//  - Sub-module sata_link_dpram: simple dual-port RAM, 1 write / 1 read port,
//    registered read, no reset on the array, inferable on Arria V / Arria 10.
//  - Top level: pointer/commit logic, frame counter, output prefetch register.
// TESTING
//  1 CUT_THROUGH, DEPTH=8: write 8 words 0..7, eop on 7
//    -> wr_full=1 after the 8th write
//    -> 9th wr_req gives wr_ovf=1 for one cycle
//    -> reads return 0..7 with rd_eop only on 7, then rd_empty=1.
//  2 STORE_FORWARD: write words A0..A3, eop on A3
//    -> rd_empty stays 1 through the A2 write
//    -> rd_empty=0 two cycles after the A3 write, rd_data=A0, rd_frames=1.
//  3 STORE_FORWARD: write 3 words, then wr_drop
//    -> stored count returns to 0, rd_empty stays 1
//    -> next frame B0..B1 reads back intact.
//  4 STORE_FORWARD, DEPTH=8: an 11-word frame overflows
//    -> wr_ovf pulses, the frame is discarded at its eop, rd_frames=0
//    -> the previously committed frame is still readable.
//  5 Simultaneous rd_req (head eop) and commit of a new eop -> rd_frames unchanged.
//    Continuous read/write at full rate for 1000 words -> no loss and no reordering.
//  6 Assert reset in the middle of a frame -> all outputs take their reset values on
//    the next edge; a subsequent frame passes through correctly.

Source files
------------

// File: rtl/sata_link_pkg.sv
// Shared word layout and mode names for the SATA link packet FIFO.
// The FIFO stores the end-of-frame flag alongside every data word.
package sata_link_pkg;

   localparam int SATA_DWIDTH = 32;

   localparam string MODE_CUT_THROUGH   = "CUT_THROUGH";
   localparam string MODE_STORE_FORWARD = "STORE_FORWARD";

   typedef struct packed {
      logic                   eop;
      logic [SATA_DWIDTH-1:0] data;
   } sata_word_t;

endpackage

// File: rtl/sata_link_dpram.sv
// Simple dual-port RAM: one write port and one registered read port.
// The array has no reset, so it can map onto block RAM.
module sata_link_dpram #(
   parameter int WIDTH = 33,
   parameter int AW    = 7
) (
   input  logic             clk,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   localparam int DEPTH = 1 << AW;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk) begin
      rd_data_o <= mem[rd_addr_i];
   end

endmodule

// File: rtl/sata_link_pkt_fifo.sv
// Frame-aware synchronous FIFO between the SATA Link FSM and the Transport layer.
// In store-and-forward mode a frame only becomes readable once its EOP word is written.
module sata_link_pkt_fifo
   import sata_link_pkg::*;
#(
   parameter int    DWIDTH       = 32,
   parameter int    DEPTH        = 128,
   parameter int    ALMOST_EMPTY = 2,
   parameter int    ALMOST_FULL  = DEPTH / 2,
   parameter string MODE         = MODE_CUT_THROUGH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DWIDTH-1:0]      wr_data,
   input  logic                   wr_eop,
   input  logic                   wr_req,
   input  logic                   wr_drop,
   output logic                   wr_full,
   output logic                   wr_almostfull,
   output logic                   wr_ovf,
   output logic [DWIDTH-1:0]      rd_data,
   output logic                   rd_eop,
   input  logic                   rd_req,
   output logic                   rd_empty,
   output logic                   rd_almostempty,
   output logic [$clog2(DEPTH):0] rd_frames
);

   localparam int AW        = $clog2(DEPTH);
   localparam int PW        = AW + 1;
   localparam bit STORE_FWD = (MODE == MODE_STORE_FORWARD);

   typedef struct packed {
      logic              eop;
      logic [DWIDTH-1:0] data;
   } word_t;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] cm_ptr_q, cm_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] frames_q, frames_d;
   logic          drop_pend_q, drop_pend_d;
   logic          ovf_q, ovf_d;
   logic          out_valid_q, out_valid_d;

   logic [PW-1:0] stored, readable;
   logic          full, pop, ram_we, frame_inc;
   word_t         ram_wdata, ram_rdata;

   assign stored   = wr_ptr_q - rd_ptr_q;
   assign readable = cm_ptr_q - rd_ptr_q;
   assign full     = (stored == PW'(DEPTH));

   // A rejected non-EOP word starts a discard that runs until the frame's EOP arrives.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      cm_ptr_d    = cm_ptr_q;
      drop_pend_d = drop_pend_q;
      ovf_d       = 1'b0;
      ram_we      = 1'b0;
      frame_inc   = 1'b0;
      if (!STORE_FWD) begin
         if (wr_req && !full) begin
            ram_we    = 1'b1;
            wr_ptr_d  = wr_ptr_q + PW'(1);
            cm_ptr_d  = wr_ptr_d;
            frame_inc = wr_eop;
         end
         ovf_d = wr_req && full;
      end else if (wr_drop) begin
         wr_ptr_d    = cm_ptr_q;
         drop_pend_d = 1'b0;
      end else if (drop_pend_q) begin
         if (wr_req && wr_eop) begin
            wr_ptr_d    = cm_ptr_q;
            drop_pend_d = 1'b0;
         end
      end else if (wr_req && full) begin
         ovf_d = 1'b1;
         if (wr_eop) begin
            wr_ptr_d = cm_ptr_q;
         end else begin
            drop_pend_d = 1'b1;
         end
      end else if (wr_req) begin
         ram_we   = 1'b1;
         wr_ptr_d = wr_ptr_q + PW'(1);
         if (wr_eop) begin
            cm_ptr_d  = wr_ptr_q + PW'(1);
            frame_inc = 1'b1;
         end
      end
   end

   // The RAM always reads the next head address, so a pop is refilled on the following cycle.
   assign pop         = rd_req && out_valid_q;
   assign rd_ptr_d    = rd_ptr_q + PW'(pop);
   assign out_valid_d = ((cm_ptr_q - rd_ptr_d) != '0);
   assign frames_d    = frames_q + PW'(frame_inc) - PW'(pop && ram_rdata.eop);

   assign ram_wdata.eop  = wr_eop;
   assign ram_wdata.data = wr_data;

   sata_link_dpram #(
      .WIDTH ($bits(word_t)),
      .AW    (AW)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (ram_we),
      .wr_addr_i (wr_ptr_q[AW-1:0]),
      .wr_data_i (ram_wdata),
      .rd_addr_i (rd_ptr_d[AW-1:0]),
      .rd_data_o (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         cm_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         frames_q    <= '0;
         drop_pend_q <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         cm_ptr_q    <= cm_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         frames_q    <= frames_d;
         drop_pend_q <= drop_pend_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   // The RAM output is unreset, so the head is masked to zero while nothing is valid.
   assign rd_data        = out_valid_q ? ram_rdata.data : '0;
   assign rd_eop         = out_valid_q && ram_rdata.eop;
   assign rd_empty       = !out_valid_q;
   assign rd_almostempty = (readable < PW'(ALMOST_EMPTY));
   assign wr_full        = full;
   assign wr_almostfull  = (stored >= PW'(ALMOST_FULL));
   assign wr_ovf         = ovf_q;
   assign rd_frames      = frames_q;

endmodule

// File: tb/tb_sata_link_pkt_fifo.sv
// Scoreboard bench for sata_link_pkt_fifo: a cut-through and a store-and-forward
// instance (both DEPTH=8) driven with directed frames; popped words are checked in order.
module tb_sata_link_pkt_fifo;
   import sata_link_pkg::*;

   localparam int DW = 32;
   localparam int FW = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [DW-1:0] ctWrData, ctRdData, sfWrData, sfRdData;
   logic          ctWrEop, ctWrReq, ctWrDrop, ctWrFull, ctWrAlmostFull, ctWrOvf;
   logic          ctRdEop, ctRdReq, ctRdEmpty, ctRdAlmostEmpty;
   logic          sfWrEop, sfWrReq, sfWrDrop, sfWrFull, sfWrAlmostFull, sfWrOvf;
   logic          sfRdEop, sfRdReq, sfRdEmpty, sfRdAlmostEmpty;
   logic [FW-1:0] ctRdFrames, sfRdFrames;

   int checks   = 0;
   int failures = 0;
   sata_word_t ctExp[$];
   sata_word_t sfExp[$];

   sata_link_pkt_fifo #(
      .DWIDTH(DW), .DEPTH(8), .ALMOST_EMPTY(2), .ALMOST_FULL(4), .MODE("CUT_THROUGH")
   ) dutCt (
      .clk(clk), .reset(reset),
      .wr_data(ctWrData), .wr_eop(ctWrEop), .wr_req(ctWrReq), .wr_drop(ctWrDrop),
      .wr_full(ctWrFull), .wr_almostfull(ctWrAlmostFull), .wr_ovf(ctWrOvf),
      .rd_data(ctRdData), .rd_eop(ctRdEop), .rd_req(ctRdReq), .rd_empty(ctRdEmpty),
      .rd_almostempty(ctRdAlmostEmpty), .rd_frames(ctRdFrames)
   );

   sata_link_pkt_fifo #(
      .DWIDTH(DW), .DEPTH(8), .ALMOST_EMPTY(2), .ALMOST_FULL(4), .MODE("STORE_FORWARD")
   ) dutSf (
      .clk(clk), .reset(reset),
      .wr_data(sfWrData), .wr_eop(sfWrEop), .wr_req(sfWrReq), .wr_drop(sfWrDrop),
      .wr_full(sfWrFull), .wr_almostfull(sfWrAlmostFull), .wr_ovf(sfWrOvf),
      .rd_data(sfRdData), .rd_eop(sfRdEop), .rd_req(sfRdReq), .rd_empty(sfRdEmpty),
      .rd_almostempty(sfRdAlmostEmpty), .rd_frames(sfRdFrames)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // One clock of stimulus; the selected instance gets the write/read, the other idles.
   task automatic applyStimulus(input bit sf, input bit req, input logic [DW-1:0] d,
                                input bit eop, input bit drop, input bit keep, input bit rd);
      sata_word_t w;
      @(posedge clk);
      #1;
      w.eop    = eop;
      w.data   = d;
      ctWrReq  = !sf && req;
      ctWrData = d;
      ctWrEop  = eop;
      ctWrDrop = !sf && drop;
      ctRdReq  = !sf && rd;
      sfWrReq  = sf && req;
      sfWrData = d;
      sfWrEop  = eop;
      sfWrDrop = sf && drop;
      sfRdReq  = sf && rd;
      if (req && keep) begin
         if (sf) sfExp.push_back(w);
         else    ctExp.push_back(w);
      end
   endtask

   task automatic idle(input bit sf, input bit rd);
      applyStimulus(sf, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, rd);
   endtask

   // Monitors: every accepted pop is compared against the head of the expected queue.
   always @(negedge clk) begin : ctMonitor
      sata_word_t e;
      if (!reset && ctRdReq && !ctRdEmpty) begin
         if (ctExp.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL ctPop actual=%0h expected=none", ctRdData);
         end else begin
            e = ctExp.pop_front();
            checkOutput("ctPopData", ctRdData, e.data);
            checkOutput("ctPopEop", ctRdEop, e.eop);
         end
      end
   end

   always @(negedge clk) begin : sfMonitor
      sata_word_t e;
      if (!reset && sfRdReq && !sfRdEmpty) begin
         if (sfExp.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sfPop actual=%0h expected=none", sfRdData);
         end else begin
            e = sfExp.pop_front();
            checkOutput("sfPopData", sfRdData, e.data);
            checkOutput("sfPopEop", sfRdEop, e.eop);
         end
      end
   end

   initial begin
      #100000;
      failures++;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset    = 1'b1;
      ctWrData = '0; ctWrEop = 1'b0; ctWrReq = 1'b0; ctWrDrop = 1'b0; ctRdReq = 1'b0;
      sfWrData = '0; sfWrEop = 1'b0; sfWrReq = 1'b0; sfWrDrop = 1'b0; sfRdReq = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstSfEmpty", sfRdEmpty, 1);
      checkOutput("rstSfAlmostEmpty", sfRdAlmostEmpty, 1);
      checkOutput("rstSfFrames", sfRdFrames, 0);
      checkOutput("rstSfData", sfRdData, 0);
      checkOutput("rstSfEop", sfRdEop, 0);
      checkOutput("rstSfFull", sfWrFull, 0);
      checkOutput("rstSfAlmostFull", sfWrAlmostFull, 0);
      checkOutput("rstSfOvf", sfWrOvf, 0);
      checkOutput("rstCtEmpty", ctRdEmpty, 1);
      reset = 1'b0;

      // Cut-through fill to full, overflow pulse, drain.
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, i, i == 7, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t1Full", ctWrFull, 1);
      checkOutput("t1AlmostFull", ctWrAlmostFull, 1);
      checkOutput("t1AlmostEmpty", ctRdAlmostEmpty, 0);
      checkOutput("t1OvfBefore", ctWrOvf, 0);
      idle(1'b0, 1'b0);
      checkOutput("t1Ovf", ctWrOvf, 1);
      idle(1'b0, 1'b0);
      checkOutput("t1OvfPulse", ctWrOvf, 0);
      checkOutput("t1Frames", ctRdFrames, 1);
      checkOutput("t1NotEmpty", ctRdEmpty, 0);
      repeat (8) idle(1'b0, 1'b1);
      idle(1'b0, 1'b0);
      checkOutput("t1Empty", ctRdEmpty, 1);
      checkOutput("t1FramesDrained", ctRdFrames, 0);
      checkOutput("t1NotFull", ctWrFull, 0);

      // Store-and-forward: frame becomes visible two cycles after its EOP write.
      for (int j = 0; j < 4; j++) begin
         applyStimulus(1'b1, 1'b1, 32'hA000_0000 + j, j == 3, 1'b0, 1'b1, 1'b0);
         if (j == 3) begin
            checkOutput("t2EmptyA2", sfRdEmpty, 1);
            checkOutput("t2FramesA2", sfRdFrames, 0);
         end
      end
      idle(1'b1, 1'b0);
      checkOutput("t2EmptyN1", sfRdEmpty, 1);
      idle(1'b1, 1'b0);
      checkOutput("t2EmptyN2", sfRdEmpty, 0);
      checkOutput("t2HeadData", sfRdData, 32'hA000_0000);
      checkOutput("t2Frames", sfRdFrames, 1);
      checkOutput("t2AlmostEmpty", sfRdAlmostEmpty, 0);
      repeat (4) idle(1'b1, 1'b1);
      idle(1'b1, 1'b0);
      checkOutput("t2Empty", sfRdEmpty, 1);
      checkOutput("t2FramesDrained", sfRdFrames, 0);

      // Drop of a partial frame (reads while empty are ignored), then a clean frame.
      for (int j = 0; j < 3; j++) applyStimulus(1'b1, 1'b1, 32'hC000_0000 + j, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'hC000_0003, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("t3EmptyBeforeDrop", sfRdEmpty, 1);
      applyStimulus(1'b1, 1'b1, 32'hB000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("t3EmptyAfterDrop", sfRdEmpty, 1);
      checkOutput("t3FramesAfterDrop", sfRdFrames, 0);
      applyStimulus(1'b1, 1'b1, 32'hB000_0001, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(1'b1, 1'b0);
      checkOutput("t3AlmostFull", sfWrAlmostFull, 0);
      checkOutput("t3Frames", sfRdFrames, 1);
      idle(1'b1, 1'b0);
      checkOutput("t3NotEmpty", sfRdEmpty, 0);
      repeat (2) idle(1'b1, 1'b1);
      idle(1'b1, 1'b0);
      checkOutput("t3Empty", sfRdEmpty, 1);

      // Overflowing 11-word frame behind a committed 2-word frame.
      applyStimulus(1'b1, 1'b1, 32'hD000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'hD000_0001, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 11; k++) begin
         applyStimulus(1'b1, 1'b1, 32'hE000_0000 + k, k == 10, 1'b0, 1'b0, 1'b0);
         if (k == 6) begin
            checkOutput("t4Full", sfWrFull, 1);
            checkOutput("t4OvfBefore", sfWrOvf, 0);
         end
         if (k == 7) checkOutput("t4Ovf", sfWrOvf, 1);
         if (k == 8) checkOutput("t4OvfPulse", sfWrOvf, 0);
      end
      idle(1'b1, 1'b0);
      checkOutput("t4FullCleared", sfWrFull, 0);
      checkOutput("t4AlmostFull", sfWrAlmostFull, 0);
      checkOutput("t4Frames", sfRdFrames, 1);
      checkOutput("t4HeadData", sfRdData, 32'hD000_0000);
      repeat (2) idle(1'b1, 1'b1);
      idle(1'b1, 1'b0);
      checkOutput("t4Empty", sfRdEmpty, 1);
      checkOutput("t4FramesDrained", sfRdFrames, 0);

      // Pop of an EOP head in the same cycle as a new commit.
      applyStimulus(1'b1, 1'b1, 32'h6000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      checkOutput("t5HeadG0", sfRdData, 32'h6000_0000);
      applyStimulus(1'b1, 1'b1, 32'h6000_0001, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(1'b1, 1'b0);
      checkOutput("t5FramesHold", sfRdFrames, 1);
      checkOutput("t5EmptyGap", sfRdEmpty, 1);
      idle(1'b1, 1'b0);
      checkOutput("t5HeadH0", sfRdData, 32'h6000_0001);
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b0);
      checkOutput("t5FramesDrained", sfRdFrames, 0);

      // Full-rate streaming through the cut-through instance.
      for (int i = 0; i < 1000; i++)
         applyStimulus(1'b0, 1'b1, 32'h1000_0000 + i, (i % 4) == 3, 1'b0, 1'b1, 1'b1);
      repeat (4) idle(1'b0, 1'b1);
      idle(1'b0, 1'b0);
      checkOutput("t5StreamEmpty", ctRdEmpty, 1);
      checkOutput("t5StreamFrames", ctRdFrames, 0);
      checkOutput("t5StreamLeft", ctExp.size(), 0);

      // Reset in the middle of a frame with a committed frame showing.
      applyStimulus(1'b1, 1'b1, 32'h7000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h7000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h7000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1'b1, 1'b0);
      checkOutput("t6PreEmpty", sfRdEmpty, 0);
      checkOutput("t6PreFrames", sfRdFrames, 1);
      reset = 1'b1;
      idle(1'b1, 1'b0);
      checkOutput("t6Empty", sfRdEmpty, 1);
      checkOutput("t6AlmostEmpty", sfRdAlmostEmpty, 1);
      checkOutput("t6Frames", sfRdFrames, 0);
      checkOutput("t6Data", sfRdData, 0);
      checkOutput("t6Eop", sfRdEop, 0);
      checkOutput("t6Full", sfWrFull, 0);
      checkOutput("t6AlmostFull", sfWrAlmostFull, 0);
      checkOutput("t6Ovf", sfWrOvf, 0);
      reset = 1'b0;
      applyStimulus(1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h8000_0001, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      checkOutput("t6NewFrames", sfRdFrames, 1);
      checkOutput("t6NewHead", sfRdData, 32'h8000_0000);
      repeat (2) idle(1'b1, 1'b1);
      idle(1'b1, 1'b0);
      checkOutput("t6NewEmpty", sfRdEmpty, 1);
      checkOutput("sfQueueLeft", sfExp.size(), 0);
      checkOutput("ctQueueLeft", ctExp.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
